// File: rtl/xga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : xga_timing_gen
// Summary  : Raster timing generator (1024x768@60 default) with registered
//            position, blanking, sync, line/frame strobes and frame counter.
// Revision : 1.0 - initial release
// ============================================================================
module xga_timing_gen #(
  parameter int H_ACTIVE   = 1024,
  parameter int H_FP       = 24,
  parameter int H_SYNC     = 136,
  parameter int H_BP       = 160,
  parameter int V_ACTIVE   = 768,
  parameter int V_FP       = 3,
  parameter int V_SYNC     = 6,
  parameter int V_BP       = 29,
  parameter bit H_SYNC_POL = 1'b0,
  parameter bit V_SYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  output logic [10:0] pix_x,
  output logic [10:0] pix_y,
  output logic        video_active,
  output logic        hsync,
  output logic        vsync,
  output logic        line_start,
  output logic        frame_start,
  output logic [15:0] frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  generate
    if (H_TOTAL > 2048) begin : g_h_total_chk
      $error("xga_timing_gen: H_TOTAL exceeds 2048");
    end
    if (V_TOTAL > 2048) begin : g_v_total_chk
      $error("xga_timing_gen: V_TOTAL exceeds 2048");
    end
  endgenerate

  // Comparisons are done 12 bits wide so a range end equal to 2048 still fits.
  localparam logic [10:0] H_LAST       = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST       = 11'(V_TOTAL - 1);
  localparam logic [11:0] H_ACT        = 12'(H_ACTIVE);
  localparam logic [11:0] V_ACT        = 12'(V_ACTIVE);
  localparam logic [11:0] H_SYNC_START = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] H_SYNC_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] V_SYNC_START = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] V_SYNC_END   = 12'(V_ACTIVE + V_FP + V_SYNC);

  logic [10:0] h_cnt_q, h_cnt_d;
  logic [10:0] v_cnt_q, v_cnt_d;
  logic [10:0] pix_x_q, pix_y_q;
  logic        video_active_q, video_active_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        line_start_q, line_start_d;
  logic        frame_start_q, frame_start_d;
  logic [15:0] frame_count_q;
  logic [11:0] h_ext, v_ext;

  assign h_ext = {1'b0, h_cnt_q};
  assign v_ext = {1'b0, v_cnt_q};

  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (ce) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 11'd1;
      end else begin
        h_cnt_d = h_cnt_q + 11'd1;
      end
    end
  end

  // A wrap is recognised by the shown position having been the last column
  // while the counter now reads zero; holding with ce=0 cannot re-trigger it.
  always_comb begin
    video_active_d = (h_ext < H_ACT) && (v_ext < V_ACT);
    hsync_d        = ((h_ext >= H_SYNC_START) && (h_ext < H_SYNC_END)) ? H_SYNC_POL : ~H_SYNC_POL;
    vsync_d        = ((v_ext >= V_SYNC_START) && (v_ext < V_SYNC_END)) ? V_SYNC_POL : ~V_SYNC_POL;
    line_start_d   = (h_cnt_q == 11'd0) && (pix_x_q == H_LAST);
    frame_start_d  = line_start_d && (v_cnt_q == 11'd0) && (pix_y_q == V_LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt_q        <= '0;
      v_cnt_q        <= '0;
      pix_x_q        <= '0;
      pix_y_q        <= '0;
      video_active_q <= 1'b0;
      hsync_q        <= ~H_SYNC_POL;
      vsync_q        <= ~V_SYNC_POL;
      line_start_q   <= 1'b0;
      frame_start_q  <= 1'b0;
      frame_count_q  <= '0;
    end else begin
      h_cnt_q        <= h_cnt_d;
      v_cnt_q        <= v_cnt_d;
      pix_x_q        <= h_cnt_q;
      pix_y_q        <= v_cnt_q;
      video_active_q <= video_active_d;
      hsync_q        <= hsync_d;
      vsync_q        <= vsync_d;
      line_start_q   <= line_start_d;
      frame_start_q  <= frame_start_d;
      frame_count_q  <= frame_count_q + {15'd0, frame_start_d};
    end
  end

  assign pix_x        = pix_x_q;
  assign pix_y        = pix_y_q;
  assign video_active = video_active_q;
  assign hsync        = hsync_q;
  assign vsync        = vsync_q;
  assign line_start   = line_start_q;
  assign frame_start  = frame_start_q;
  assign frame_count  = frame_count_q;

endmodule
`default_nettype wire
